// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the BCH decode sequencer: state encoding, code selects
// and a width helper for the test-pattern index.
package decode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYN   = 3'd1,
        ST_CHK   = 3'd2,
        ST_BM    = 3'd3,
        ST_CHIEN = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] CODE_A   = 2'b00;
    localparam logic [1:0] CODE_B   = 2'b01;
    localparam logic [1:0] CODE_C   = 2'b10;
    localparam logic [1:0] CODE_ILL = 2'b11;

    function automatic int tp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decode_ctrl_pulser.sv
// Edge-to-pulse cell: one-cycle strobe in the first cycle a level goes high.
// Output follows the registered level source with zero added latency.
module decode_ctrl_pulser (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    logic lvl_q;

    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b0;
        else     lvl_q <= lvl;
    end

    assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/decode_ctrl.sv
// Sequencer for one BCH codeword decode: syndrome, early-stop check, then BM and
// Chien once (hard) or once per Chase test pattern (soft), with a per-stage watchdog.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter  int N_TP    = 4,
    parameter  int ES_WAIT = 2,
    parameter  int TIMEOUT = 2047,
    localparam int TPW     = tp_width(N_TP)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_mode,
    input  logic [1:0]     i_code,
    output logic           o_busy,
    output logic [1:0]     o_code,
    output logic           o_syn_start,
    input  logic           i_syn_done,
    input  logic           i_early_stop_pulse,
    output logic           o_bm_start,
    input  logic           i_bm_done,
    output logic           o_chien_start,
    input  logic           i_chien_done,
    output logic [TPW-1:0] o_tp_idx,
    output logic           o_done,
    output logic           o_no_err,
    output logic           o_fail
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    // Abort two counts early so o_done lands exactly TIMEOUT cycles after stage entry.
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 2);
    // The i_syn_done cycle already counts as the first early-stop window cycle.
    localparam logic [WDW-1:0] WD_ES    = WDW'((ES_WAIT >= 2) ? ES_WAIT - 2 : 0);
    localparam logic [TPW-1:0] TP_LAST  = TPW'(N_TP - 1);

    state_t         state;
    logic [WDW-1:0] wd;
    logic [TPW-1:0] tp;
    logic           mode_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            wd       <= '0;
            tp       <= '0;
            mode_q   <= 1'b0;
            o_code   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_no_err <= 1'b0;
            o_fail   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            wd     <= wd + 1'b1;
            case (state)
                ST_IDLE: begin
                    wd     <= '0;
                    o_busy <= 1'b0;
                    if (i_start && !o_done) begin
                        mode_q   <= i_mode;
                        o_code   <= i_code;
                        tp       <= '0;
                        o_busy   <= 1'b1;
                        o_no_err <= 1'b0;
                        o_fail   <= (i_code == CODE_ILL);
                        state    <= (i_code == CODE_ILL) ? ST_DONE : ST_SYN;
                    end
                end
                ST_SYN: begin
                    if (i_syn_done) begin
                        wd <= '0;
                        if (i_early_stop_pulse && tp == '0) begin
                            o_no_err <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= (ES_WAIT <= 1) ? ST_BM : ST_CHK;
                        end
                    end else if (wd == WD_LIMIT) begin
                        wd     <= '0;
                        o_fail <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_CHK: begin
                    if (i_early_stop_pulse && tp == '0) begin
                        wd       <= '0;
                        o_no_err <= 1'b1;
                        state    <= ST_DONE;
                    end else if (wd >= WD_ES) begin
                        wd    <= '0;
                        state <= ST_BM;
                    end
                end
                ST_BM: begin
                    if (i_bm_done) begin
                        wd    <= '0;
                        state <= ST_CHIEN;
                    end else if (wd == WD_LIMIT) begin
                        wd     <= '0;
                        o_fail <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_CHIEN: begin
                    if (i_chien_done) begin
                        wd    <= '0;
                        state <= ST_NEXT;
                    end else if (wd == WD_LIMIT) begin
                        wd     <= '0;
                        o_fail <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_NEXT: begin
                    wd <= '0;
                    // Later patterns reuse precomputed syndromes, so loop straight to BM.
                    if (!mode_q || tp == TP_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        tp    <= tp + 1'b1;
                        state <= ST_BM;
                    end
                end
                ST_DONE: begin
                    wd     <= '0;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    wd    <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tp_idx = tp;

    decode_ctrl_pulser u_syn_pulse (
        .clk   (i_clk),
        .rst   (i_rst),
        .lvl   (state == ST_SYN),
        .pulse (o_syn_start)
    );

    decode_ctrl_pulser u_bm_pulse (
        .clk   (i_clk),
        .rst   (i_rst),
        .lvl   (state == ST_BM),
        .pulse (o_bm_start)
    );

    decode_ctrl_pulser u_chien_pulse (
        .clk   (i_clk),
        .rst   (i_rst),
        .lvl   (state == ST_CHIEN),
        .pulse (o_chien_start)
    );

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: scripted sub-unit responses, hand-computed cycle timing.
module tb_decode_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_mode = 1'b0;
    logic [1:0] i_code = 2'b00;
    logic       i_syn_done = 1'b0;
    logic       i_early_stop_pulse = 1'b0;
    logic       i_bm_done = 1'b0;
    logic       i_chien_done = 1'b0;
    logic       o_busy, o_syn_start, o_bm_start, o_chien_start, o_done, o_no_err, o_fail;
    logic [1:0] o_code;
    logic [1:0] o_tp_idx;

    int checks = 0;
    int errors = 0;

    int n_syn, n_bm, n_ch, n_done, done_r, bm_r;
    logic d_no_err, d_fail, d_busy;
    logic [1:0] d_tp, d_code;
    logic [10:0] rst_snap;
    int tp_q[$];

    decode_ctrl #(.N_TP(4), .ES_WAIT(2), .TIMEOUT(2047)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_mode             (i_mode),
        .i_code             (i_code),
        .o_busy             (o_busy),
        .o_code             (o_code),
        .o_syn_start        (o_syn_start),
        .i_syn_done         (i_syn_done),
        .i_early_stop_pulse (i_early_stop_pulse),
        .o_bm_start         (o_bm_start),
        .i_bm_done          (i_bm_done),
        .o_chien_start      (o_chien_start),
        .i_chien_done       (i_chien_done),
        .o_tp_idx           (o_tp_idx),
        .o_done             (o_done),
        .o_no_err           (o_no_err),
        .o_fail             (o_fail)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 1'b0; i_syn_done = 1'b0; i_early_stop_pulse = 1'b0;
        i_bm_done = 1'b0; i_chien_done = 1'b0; i_rst = 1'b0;
    endtask

    // Cycle r=0 drives i_start; latencies are counted from each observed start strobe.
    // A negative latency withholds that done; es_at/rst_at are absolute cycles (-1 = never).
    task automatic run_decode(input logic mode, input logic [1:0] code, input int syn_lat,
                              input int es_at, input int bm_lat, input int ch_lat,
                              input int rst_at, input int max_r);
        int syn_due, bm_due, ch_due;
        n_syn = 0; n_bm = 0; n_ch = 0; n_done = 0; done_r = -1; bm_r = -1;
        d_no_err = 1'bx; d_fail = 1'bx; d_busy = 1'bx; d_tp = 2'bxx; d_code = 2'bxx;
        rst_snap = 11'h7ff; tp_q.delete();
        syn_due = -1; bm_due = -1; ch_due = -1;
        for (int r = 0; r <= max_r; r++) begin
            if (r > 0) begin
                if (o_syn_start) begin
                    n_syn++;
                    if (syn_lat >= 0) syn_due = r + syn_lat;
                end
                if (o_bm_start) begin
                    n_bm++;
                    tp_q.push_back(int'(o_tp_idx));
                    if (bm_r < 0) bm_r = r;
                    if (bm_lat >= 0) bm_due = r + bm_lat;
                end
                if (o_chien_start) begin
                    n_ch++;
                    if (ch_lat >= 0) ch_due = r + ch_lat;
                end
                if (r == rst_at + 1)
                    rst_snap = {o_busy, o_code, o_tp_idx, o_done, o_no_err, o_fail,
                                o_syn_start, o_bm_start, o_chien_start};
                if (o_done) begin
                    n_done++; done_r = r; d_no_err = o_no_err; d_fail = o_fail;
                    d_tp = o_tp_idx; d_code = o_code; d_busy = o_busy;
                    break;
                end
            end
            i_start            = (r == 0);
            i_mode             = mode;
            i_code             = code;
            i_syn_done         = (r == syn_due);
            i_early_stop_pulse = (r == es_at);
            i_bm_done          = (r == bm_due);
            i_chien_done       = (r == ch_due);
            i_rst              = (r == rst_at);
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        checks++;
        if ({o_busy, o_done, o_no_err, o_fail} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b expected 0000", {o_busy, o_done, o_no_err, o_fail});
        end
        checks++;
        if ({o_code, o_tp_idx, o_syn_start, o_bm_start, o_chien_start} !== 7'b0) begin
            errors++; $display("FAIL reset_data: got %b expected 0000000",
                               {o_code, o_tp_idx, o_syn_start, o_bm_start, o_chien_start});
        end
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_early_stop();
        // syn_done at +5, early pulse at +6 (in CHK) -> DONE at +7, o_done at +8
        run_decode(1'b0, 2'b00, 4, 6, 3, 2, -1, 60);
        checks++;
        if (done_r !== 8) begin errors++; $display("FAIL es_done_cycle: got %0d expected 8", done_r); end
        checks++;
        if (n_bm !== 0 || n_ch !== 0) begin
            errors++; $display("FAIL es_no_bm: got bm=%0d chien=%0d expected 0/0", n_bm, n_ch);
        end
        checks++;
        if ({d_no_err, d_fail, d_busy} !== 3'b101) begin
            errors++; $display("FAIL es_flags: got %b expected 101", {d_no_err, d_fail, d_busy});
        end
        checks++;
        if (n_syn !== 1) begin errors++; $display("FAIL es_syn_start: got %0d expected 1", n_syn); end
        step();
    endtask

    task automatic test_early_same_cycle();
        // early pulse coincides with syn_done: early stop wins, o_done at +7
        run_decode(1'b0, 2'b01, 4, 5, 3, 2, -1, 60);
        checks++;
        if (done_r !== 7 || d_no_err !== 1'b1 || n_bm !== 0) begin
            errors++; $display("FAIL es_same_cycle: got done=%0d no_err=%b bm=%0d expected 7/1/0",
                               done_r, d_no_err, n_bm);
        end
        step();
    endtask

    task automatic test_early_outside_chk();
        // pulse at +3 is in SYN before syn_done: ignored, full hard decode follows
        run_decode(1'b0, 2'b01, 4, 3, 3, 2, -1, 60);
        checks++;
        if (done_r !== 16 || d_no_err !== 1'b0 || n_bm !== 1) begin
            errors++; $display("FAIL es_outside: got done=%0d no_err=%b bm=%0d expected 16/0/1",
                               done_r, d_no_err, n_bm);
        end
        step();
    endtask

    task automatic test_hard();
        // SYN 1..5, CHK 6, BM 7..10, CHIEN 11..13, NEXT 14, DONE 15, o_done 16
        run_decode(1'b0, 2'b10, 4, -1, 3, 2, -1, 60);
        checks++;
        if (n_bm !== 1 || n_ch !== 1) begin
            errors++; $display("FAIL hard_pairs: got bm=%0d chien=%0d expected 1/1", n_bm, n_ch);
        end
        checks++;
        if (done_r !== 16) begin errors++; $display("FAIL hard_done_cycle: got %0d expected 16", done_r); end
        checks++;
        if ({d_tp, d_code, d_no_err, d_fail} !== 6'b00_10_00) begin
            errors++; $display("FAIL hard_result: got %b expected 001000", {d_tp, d_code, d_no_err, d_fail});
        end
        step();
    endtask

    task automatic test_soft();
        // 8 cycles per pattern after the first BM at +7; last DONE at +39, o_done at +40
        run_decode(1'b1, 2'b01, 4, -1, 3, 2, -1, 120);
        checks++;
        if (n_bm !== 4 || n_ch !== 4 || n_done !== 1) begin
            errors++; $display("FAIL soft_pairs: got bm=%0d chien=%0d done=%0d expected 4/4/1", n_bm, n_ch, n_done);
        end
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (i < tp_q.size()) ? tp_q[i] : -1;
            checks++;
            if (v !== i) begin errors++; $display("FAIL soft_tp_idx%0d: got %0d expected %0d", i, v, i); end
        end
        checks++;
        if (done_r !== 40 || d_tp !== 2'd3 || {d_no_err, d_fail} !== 2'b00) begin
            errors++; $display("FAIL soft_done: got cycle=%0d tp=%0d flags=%b expected 40/3/00",
                               done_r, d_tp, {d_no_err, d_fail});
        end
        step();
        checks++;
        if ({o_busy, o_done} !== 2'b00 || o_tp_idx !== 2'd3 || o_code !== 2'b01) begin
            errors++; $display("FAIL soft_hold: got busy=%b done=%b tp=%0d code=%0d expected 0/0/3/1",
                               o_busy, o_done, o_tp_idx, o_code);
        end
    endtask

    task automatic test_illegal();
        run_decode(1'b0, 2'b11, 4, -1, 3, 2, -1, 20);
        checks++;
        if (done_r !== 2 || d_fail !== 1'b1 || d_no_err !== 1'b0) begin
            errors++; $display("FAIL illegal_done: got cycle=%0d fail=%b no_err=%b expected 2/1/0",
                               done_r, d_fail, d_no_err);
        end
        checks++;
        if (n_syn !== 0 || n_bm !== 0) begin
            errors++; $display("FAIL illegal_no_syn: got syn=%0d bm=%0d expected 0/0", n_syn, n_bm);
        end
        step();
    endtask

    task automatic test_timeout();
        run_decode(1'b0, 2'b01, 4, -1, -1, 2, -1, 2300);
        checks++;
        if (bm_r !== 7 || done_r !== bm_r + 2047) begin
            errors++; $display("FAIL timeout_cycle: got bm=%0d done=%0d expected 7/2054", bm_r, done_r);
        end
        checks++;
        if (d_fail !== 1'b1 || d_no_err !== 1'b0 || n_ch !== 0) begin
            errors++; $display("FAIL timeout_flags: got fail=%b no_err=%b chien=%0d expected 1/0/0",
                               d_fail, d_no_err, n_ch);
        end
        step();
    endtask

    task automatic test_reset_in_chien();
        run_decode(1'b0, 2'b10, 4, -1, 3, 20, 12, 40);
        checks++;
        if (n_ch !== 1) begin errors++; $display("FAIL rst_reached_chien: got %0d expected 1", n_ch); end
        checks++;
        if (rst_snap !== 11'b0) begin
            errors++; $display("FAIL rst_outputs: got %b expected 00000000000", rst_snap);
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", n_done); end
        run_decode(1'b0, 2'b00, 4, 6, 3, 2, -1, 60);
        checks++;
        if (done_r !== 8 || d_no_err !== 1'b1 || d_fail !== 1'b0) begin
            errors++; $display("FAIL rst_restart: got cycle=%0d no_err=%b fail=%b expected 8/1/0",
                               done_r, d_no_err, d_fail);
        end
        step();
    endtask

    task automatic test_back_to_back();
        run_decode(1'b0, 2'b11, 4, -1, 3, 2, -1, 20);
        // now in the o_done cycle: a start here must be ignored
        i_start = 1'b1; i_mode = 1'b0; i_code = 2'b00;
        step();
        checks++;
        if ({o_busy, o_syn_start} !== 2'b00) begin
            errors++; $display("FAIL b2b_ignored: got busy=%b syn=%b expected 0/0", o_busy, o_syn_start);
        end
        step();
        checks++;
        if ({o_busy, o_syn_start} !== 2'b11) begin
            errors++; $display("FAIL b2b_accepted: got busy=%b syn=%b expected 1/1", o_busy, o_syn_start);
        end
        // a start while busy must not relatch the code
        i_code = 2'b11; i_syn_done = 1'b1; i_early_stop_pulse = 1'b1;
        step();
        clear_inputs();
        step();
        checks++;
        if ({o_done, o_no_err, o_fail} !== 3'b110 || o_code !== 2'b00) begin
            errors++; $display("FAIL b2b_result: got done/no_err/fail=%b code=%0d expected 110/0",
                               {o_done, o_no_err, o_fail}, o_code);
        end
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_early_stop();
        test_early_same_cycle();
        test_early_outside_chk();
        test_hard();
        test_soft();
        test_illegal();
        test_timeout();
        test_reset_in_chien();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
